// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, prescaler
// sizing, BCD helpers and the seven-segment decode table.
package countdown_timer_pkg;

    localparam int PRESC_W          = 26;
    localparam int TICK_DIV_DEFAULT = 50000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Two-digit BCD decrement that saturates at 00 instead of wrapping.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Active-low segments, index 0 = a ... index 6 = g; non-BCD codes blank.
    function automatic logic [0:6] seg7_decode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the countdown timer and its user.
interface countdown_timer_if;

    logic       Load;
    logic [7:0] LoadVal;
    logic       Start;
    logic       Pause;
    logic [7:0] Count;
    logic       Running;
    logic       Done;
    logic       Tick;
    logic [0:6] HEX0;
    logic [0:6] HEX1;

    modport master (
        output Load, LoadVal, Start, Pause,
        input  Count, Running, Done, Tick, HEX0, HEX1
    );

    modport slave (
        input  Load, LoadVal, Start, Pause,
        output Count, Running, Done, Tick, HEX0, HEX1
    );

endinterface

// File: rtl/countdown_timer_bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment pattern (a..g on [0:6]).
module bcd_to_seg7
    import countdown_timer_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [0:6] seg_o
);

    assign seg_o = seg7_decode(bcd_i);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with prescaled step, pause/resume and
// seven-segment display of the current value.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               Clr,
    countdown_timer_if.slave   bus
);

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [7:0]         count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_s;
    logic [7:0]         dec_s;
    logic [0:6]         hex0_s, hex1_s;

    assign tick_s = (state_q == ST_RUN) && (presc_q == TICK_LAST);
    assign dec_s  = bcd_dec(count_q);

    // Next-state, next-count and prescaler control in priority order.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        if (bus.Load && (state_q != ST_RUN)) begin
            count_d = {clamp_digit(bus.LoadVal[7:4]), clamp_digit(bus.LoadVal[3:0])};
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (bus.Start) begin
                        if (count_q == 8'h00) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Pause beats a coinciding Tick: the prescaler keeps its
                    // value so the pending step fires right after resume.
                    if (bus.Pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick_s) begin
                        presc_d = '0;
                        count_d = dec_s;
                        if (dec_s == 8'h00) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PAUSE: begin
                    if (bus.Start && !bus.Pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    presc_d = '0;
                    count_d = 8'h00;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 8'h00;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, count and prescaler registers with asynchronous clear.
    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            count_q <= 8'h00;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    bcd_to_seg7 u_seg_units (
        .bcd_i (count_q[3:0]),
        .seg_o (hex0_s)
    );

    bcd_to_seg7 u_seg_tens (
        .bcd_i (count_q[7:4]),
        .seg_o (hex1_s)
    );

    assign bus.Count   = count_q;
    assign bus.Running = (state_q == ST_RUN);
    assign bus.Done    = (state_q == ST_DONE);
    assign bus.Tick    = tick_s;
    assign bus.HEX0    = hex0_s;
    assign bus.HEX1    = hex1_s;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLOCK_50 cycles per count step (1 s at 50 MHz); legal range 2..2^26.
REQ-002 CLOCK_50  input  1  system clock; all state changes on posedge.
REQ-003 Clr  input  1  reset, asynchronous, active-high.
REQ-004 Load  input  1  synchronous load strobe for LoadVal.
REQ-005 LoadVal  input  8  start value as two BCD digits: [7:4] tens, [3:0] units.
REQ-006 Start  input  1  start or resume countdown.
REQ-007 Pause  input  1  suspend countdown.
REQ-008 Count  output  8  current value as two BCD digits.
REQ-009 Running  output  1  high only in state RUN.
REQ-010 Done  output  1  high only in state DONE.
REQ-011 Tick  output  1  one-cycle pulse on each prescaler wrap while in RUN.
REQ-012 HEX0, HEX1  output  7 each, bit order [0:6]  units and tens digits, active-low, bit 0 = segment a ... bit 6 = segment g.

Function
REQ-013 States: IDLE, RUN, PAUSE, DONE; exactly one active.
REQ-014 Prescaler: 26-bit counter; increments only in RUN, holds in PAUSE, cleared to 0 in IDLE and DONE and on the IDLE->RUN transition; Tick asserts on the cycle it equals TICK_DIV-1, and it wraps to 0 on the next edge.
REQ-015 Load accepted in IDLE, PAUSE and DONE: Count <= LoadVal, state -> IDLE, prescaler cleared; ignored in RUN.
REQ-016 A LoadVal digit > 9 is clamped to 9 on load.
REQ-017 IDLE + Start: Count != 00 -> RUN; Count == 00 -> DONE.
REQ-018 RUN: on each Tick, Count decrements by 1 in BCD (units 0 borrows: units <= 9, tens <= tens-1); when the decrement produces 00, state -> DONE on the same edge.
REQ-019 RUN + Pause -> PAUSE; Pause wins over Start when both are high.
REQ-020 PAUSE + Start (Pause low) -> RUN; prescaler resumes from its held value.
REQ-021 DONE holds Count = 00 until Load or Clr; Start is ignored.
REQ-022 Same-cycle priority: Clr > Load > Pause > Start > Tick decrement; a Pause coinciding with Tick pauses without decrementing.
REQ-023 Count never wraps below 00 and never holds a non-BCD digit.
REQ-024 HEX outputs combinational from Count; the same-edge decode shows digits 0-9 only.

Reset
REQ-025 Clr high: state IDLE, Count 00, prescaler 0, Tick 0, Running 0, Done 0; HEX0/HEX1 show "0" (0000001).
REQ-026 Clr asserted mid-RUN aborts immediately; no Tick or decrement after release until a new Start.

Structure
REQ-027 Shared package holds the state encoding (2-bit, IDLE=00 RUN=01 PAUSE=10 DONE=11), the BCD-to-segment table, and the TICK_DIV default.
REQ-028 One sub-module, bcd_to_seg7 (4-bit BCD in, 7-bit active-low segments out), instantiated twice.
REQ-029 Prescaler, BCD decrement and FSM live in countdown_timer; no derived clocks, and only CLOCK_50 drives edge-sensitive logic.

Verification (TICK_DIV = 4)
REQ-030 Clr pulse, then Load with LoadVal=0x12, then Start -> Running=1; Count goes 12, 11, 10, 09, ... at one Tick per 4 cycles; after 12 Ticks Count=00 and Done=1, Running=0.
REQ-031 Load 0x10, Start, run 1 Tick -> Count=09, HEX1=0000001, HEX0=0000100.
REQ-032 Start, then Pause after 2 cycles, hold 20 cycles, then Start -> no Tick during pause; first Tick 2 cycles after resume.
REQ-033 Load LoadVal=0xAF -> Count=0x99; Load 0x00 then Start -> DONE next edge, no Tick.
REQ-034 In RUN, assert Load -> ignored; assert Pause and Start in the same cycle -> PAUSE; assert Clr mid-count -> all outputs at reset values asynchronously.
REQ-035 In DONE, Start -> no change; Load 0x05, Start -> counts 05 to 00 in 5 Ticks.
